issue_select: RTL and testbench
===============================

ISSUE_SELECT -- requirements
Module: issue_select

Interface
- REQ-001: Parameter bs, default 16, is the number of instruction-buffer entries; index width IW = $clog2(bs).
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: rst  input  1  asynchronous, active-low reset.
- REQ-004: alloc_valid  input  1  a dependency row is written for one buffer entry this cycle.
- REQ-005: alloc_index  input  IW  buffer entry being written.
- REQ-006: alloc_row  input  bs  dependency row for that entry, as produced by the dependency-analysis stage; bit j=1 means dependent on entry j.
- REQ-007: complete_valid  input  1  one issued instruction finished execution this cycle.
- REQ-008: complete_index  input  IW  entry that finished.
- REQ-009: issue_ready  input  1  downstream accepts the offered index.
- REQ-010: issue_valid  output  1  issue_index holds a ready entry.
- REQ-011: issue_index  output  IW  entry offered for issue.
- REQ-012: occupancy  output  IW+1  count of entries not FREE.
- REQ-013: err  output  1  sticky protocol-error flag.

Function
- REQ-014: Each entry shall hold a state (FREE, WAITING, ISSUED) and a bs-bit dependency row.
- REQ-015: Accepted alloc (target FREE) shall store alloc_row with bit alloc_index forced to 0 and move the entry FREE->WAITING.
- REQ-016: Alloc to a non-FREE entry shall be ignored and set err.
- REQ-017: An entry shall be ready when WAITING and all row bits are 0.
- REQ-018: Selection shall be round-robin: the first ready entry at or after pointer ptr, wrapping from bs-1 to 0; ptr resets to 0.
- REQ-019: issue_valid/issue_index shall be registered; an entry allocated at edge N with an all-zero row shall first be offered after edge N+1 (latency 1 cycle from write to offer).
- REQ-020: While issue_valid=1 and issue_ready=0, issue_valid and issue_index shall hold stable.
- REQ-021: On handshake (issue_valid & issue_ready) the offered entry shall move WAITING->ISSUED, ptr shall become issue_index+1 mod bs, and the register shall reload with the next selection (excluding the just-issued entry) at the same edge, allowing one issue per cycle.
- REQ-022: With no ready entry and no held offer, issue_valid shall be 0 and issue_index shall hold its previous value.
- REQ-023: Accepted complete (target ISSUED) shall move the entry ISSUED->FREE and clear column complete_index in every stored row.
- REQ-024: Complete to a non-ISSUED entry shall be ignored and set err.
- REQ-025: Same-cycle alloc and accepted complete: alloc_row bit complete_index shall be stored as 0.
- REQ-026: Same-cycle alloc and complete on the same index: complete applies, alloc is ignored (entry still non-FREE at sample time), err set.
- REQ-027: A column cleared by complete shall make dependents eligible for the selection performed at that same edge (offer visible next cycle).
- REQ-028: occupancy shall equal the number of WAITING plus ISSUED entries, updated at the same edge as the state change; max value bs.
- REQ-029: err, once set, shall stay 1 until reset.

Reset
- REQ-030: While rst=0: all entries FREE, all rows all-ones, ptr=0, issue_valid=0, issue_index=0, occupancy=0, err=0.
- REQ-031: Reset asserted mid-operation shall abandon any held offer immediately (asynchronously) without requiring issue_ready.
- REQ-032: Inputs shall be ignored until the first rising edge after rst returns to 1.

Verification
- REQ-033: Reset, alloc idx 3 row 0x0000 -> after next edge issue_valid=1, issue_index=3, occupancy=1.
- REQ-034: Alloc idx 5 row 0x0008 with idx 3 ISSUED; hold issue_ready=0 -> no offer of 5; complete 3 -> next cycle issue_index=5, occupancy=1.
- REQ-035: Entries 0,1,2 all ready, issue_ready=1 continuously -> issue_index 0,1,2 on consecutive cycles, then issue_valid=0.
- REQ-036: ptr=14, ready entries 2 and 15 -> 15 offered first, then 2 (wrap).
- REQ-037: Alloc idx 7 while 7 WAITING -> err=1, row of 7 unchanged; complete idx 9 while FREE -> err stays 1.
- REQ-038: Offer held with issue_ready=0, rst pulsed low -> issue_valid=0 immediately, occupancy=0.

Source files
------------

// File: rtl/issue_select.sv
// Dependency-matrix issue selector: tracks per-entry state and dependency rows,
// and offers one ready entry per cycle through a registered round-robin picker.
module issue_select #(
   parameter int bs = 16,
   localparam int IW = $clog2(bs)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          alloc_valid,
   input  logic [IW-1:0] alloc_index,
   input  logic [bs-1:0] alloc_row,
   input  logic          complete_valid,
   input  logic [IW-1:0] complete_index,
   input  logic          issue_ready,
   output logic          issue_valid,
   output logic [IW-1:0] issue_index,
   output logic [IW:0]   occupancy,
   output logic          err
);

   typedef enum logic [1:0] {
      FREE    = 2'd0,
      WAITING = 2'd1,
      ISSUED  = 2'd2
   } entryState_e;

   entryState_e   state_q [bs];
   entryState_e   state_d [bs];
   logic [bs-1:0] row_q [bs];
   logic [bs-1:0] row_d [bs];
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] issueIndex_q, issueIndex_d;
   logic          issueValid_q, issueValid_d;
   logic [IW:0]   occ_q, occ_d;
   logic          err_q, err_d;

   logic          cmpAcc, allocAcc, handshake, found;
   logic [bs-1:0] keepMask, readyVec;
   logic [IW-1:0] nextIdx, startPtr, selIdx;
   logic [IW:0]   probe;

   always_comb begin
      cmpAcc    = complete_valid && (state_q[complete_index] == ISSUED);
      allocAcc  = alloc_valid && (state_q[alloc_index] == FREE);
      handshake = issueValid_q && issue_ready;
      nextIdx   = (issueIndex_q == IW'(bs - 1)) ? '0 : issueIndex_q + 1'b1;

      // A completing column is cleared before readiness is judged, so its
      // dependents can be picked at this very edge.
      keepMask = '1;
      if (cmpAcc) keepMask[complete_index] = 1'b0;

      for (int e = 0; e < bs; e++) begin
         state_d[e]  = state_q[e];
         row_d[e]    = row_q[e] & keepMask;
         readyVec[e] = (state_q[e] == WAITING) && ((row_q[e] & keepMask) == '0);
      end

      if (handshake) begin
         readyVec[issueIndex_q] = 1'b0;
         state_d[issueIndex_q]  = ISSUED;
      end
      if (cmpAcc) state_d[complete_index] = FREE;
      if (allocAcc) begin
         state_d[alloc_index]              = WAITING;
         row_d[alloc_index]                = alloc_row & keepMask;
         row_d[alloc_index][alloc_index]   = 1'b0;
      end

      startPtr = handshake ? nextIdx : ptr_q;
      found    = 1'b0;
      selIdx   = '0;
      probe    = '0;
      for (int i = 0; i < bs; i++) begin
         probe = {1'b0, startPtr} + (IW+1)'(i);
         if (probe >= (IW+1)'(bs)) probe = probe - (IW+1)'(bs);
         if (!found && readyVec[probe[IW-1:0]]) begin
            found  = 1'b1;
            selIdx = probe[IW-1:0];
         end
      end

      ptr_d        = handshake ? nextIdx : ptr_q;
      issueValid_d = issueValid_q;
      issueIndex_d = issueIndex_q;
      if (!issueValid_q || issue_ready) begin
         issueValid_d = found;
         if (found) issueIndex_d = selIdx;
      end

      occ_d = occ_q + (IW+1)'(allocAcc) - (IW+1)'(cmpAcc);
      err_d = err_q | (alloc_valid & ~allocAcc) | (complete_valid & ~cmpAcc);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int e = 0; e < bs; e++) begin
            state_q[e] <= FREE;
            row_q[e]   <= '1;
         end
         ptr_q        <= '0;
         issueIndex_q <= '0;
         issueValid_q <= 1'b0;
         occ_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         ptr_q        <= ptr_d;
         issueIndex_q <= issueIndex_d;
         issueValid_q <= issueValid_d;
         occ_q        <= occ_d;
         err_q        <= err_d;
      end
   end

   assign issue_valid = issueValid_q;
   assign issue_index = issueIndex_q;
   assign occupancy   = occ_q;
   assign err         = err_q;

endmodule

// File: tb/tb_issue_select.sv
// Self-checking bench for issue_select: directed scenarios followed by random
// traffic compared every cycle against an entry-level behavioural model.
module tb_issue_select;

   localparam int BS = 16;
   localparam int IW = 4;
   localparam int S_FREE = 0;
   localparam int S_WAIT = 1;
   localparam int S_ISS  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          alloc_valid;
   logic [IW-1:0] alloc_index;
   logic [BS-1:0] alloc_row;
   logic          complete_valid;
   logic [IW-1:0] complete_index;
   logic          issue_ready;
   logic          issue_valid;
   logic [IW-1:0] issue_index;
   logic [IW:0]   occupancy;
   logic          err;

   int compared   = 0;
   int mismatched = 0;

   int            mSt [BS];
   logic [BS-1:0] mRow [BS];
   int            mPtr;
   bit            mValid;
   int            mIdx;
   bit            mErr;

   issue_select #(.bs(BS)) dut (
      .clk            (clk),
      .rst            (rst),
      .alloc_valid    (alloc_valid),
      .alloc_index    (alloc_index),
      .alloc_row      (alloc_row),
      .complete_valid (complete_valid),
      .complete_index (complete_index),
      .issue_ready    (issue_ready),
      .issue_valid    (issue_valid),
      .issue_index    (issue_index),
      .occupancy      (occupancy),
      .err            (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int busyCount();
      int n = 0;
      for (int e = 0; e < BS; e++) if (mSt[e] != S_FREE) n++;
      return n;
   endfunction

   task automatic modelReset();
      for (int e = 0; e < BS; e++) begin
         mSt[e]  = S_FREE;
         mRow[e] = '1;
      end
      mPtr = 0; mValid = 0; mIdx = 0; mErr = 0;
   endtask

   task automatic checkOutput(input string tag);
      check({tag, "_valid"}, issue_valid, mValid);
      check({tag, "_index"}, issue_index, mIdx);
      check({tag, "_occ"},   occupancy,   busyCount());
      check({tag, "_err"},   err,         mErr);
   endtask

   // Drives one cycle of inputs at the falling edge, advances the model to the
   // state expected after the next rising edge, then compares at the next fall.
   task automatic applyStimulus(input bit av, input int ai, input logic [BS-1:0] ar,
                                input bit cv, input int ci, input bit ir);
      bit cmpOk, allocOk, hs, hold;
      bit elig [BS];
      logic [BS-1:0] keep;
      int start, e, oldIdx;
      alloc_valid = av; alloc_index = IW'(ai); alloc_row = ar;
      complete_valid = cv; complete_index = IW'(ci); issue_ready = ir;

      cmpOk   = cv && (mSt[ci] == S_ISS);
      allocOk = av && (mSt[ai] == S_FREE);
      hs      = mValid && ir;
      hold    = mValid && !ir;
      oldIdx  = mIdx;
      keep    = '1;
      if (cmpOk) keep[ci] = 1'b0;
      for (int k = 0; k < BS; k++)
         elig[k] = (mSt[k] == S_WAIT) && ((mRow[k] & keep) == '0) && !(hs && k == oldIdx);
      for (int k = 0; k < BS; k++) mRow[k] = mRow[k] & keep;
      if (hs) mSt[oldIdx] = S_ISS;
      if (cmpOk) mSt[ci] = S_FREE;
      if (allocOk) begin
         mSt[ai]      = S_WAIT;
         mRow[ai]     = ar & keep;
         mRow[ai][ai] = 1'b0;
      end
      if ((cv && !cmpOk) || (av && !allocOk)) mErr = 1;
      if (!hold) begin
         start  = hs ? (oldIdx + 1) % BS : mPtr;
         mValid = 0;
         for (int j = 0; j < BS; j++) begin
            e = (start + j) % BS;
            if (!mValid && elig[e]) begin
               mValid = 1;
               mIdx   = e;
            end
         end
      end
      if (hs) mPtr = (oldIdx + 1) % BS;

      @(posedge clk);
      @(negedge clk);
      checkOutput("model");
   endtask

   task automatic idle(input bit ir);
      applyStimulus(0, 0, '0, 0, 0, ir);
   endtask

   task automatic doReset();
      rst = 1'b0;
      #2;
      modelReset();
      checkOutput("async_rst");
      alloc_valid = 0; complete_valid = 0; issue_ready = 0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int ai, ci, start;
      bit av, cv, ir;
      logic [BS-1:0] busy, row;
      int issuedQ[$];

      rst = 1'b0;
      alloc_valid = 0; alloc_index = '0; alloc_row = '0;
      complete_valid = 0; complete_index = '0; issue_ready = 0;
      modelReset();
      @(negedge clk);
      checkOutput("reset");
      check("rst_valid", issue_valid, 0);
      check("rst_index", issue_index, 0);
      check("rst_occ", occupancy, 0);
      check("rst_err", err, 0);
      rst = 1'b1;

      $display("[TB] single ready entry, one-cycle offer latency");
      applyStimulus(1, 3, 16'h0000, 0, 0, 0);
      check("lat_valid_early", issue_valid, 0);
      idle(0);
      check("lat_valid", issue_valid, 1);
      check("lat_index", issue_index, 3);
      check("lat_occ", occupancy, 1);

      $display("[TB] dependency released by completion");
      applyStimulus(1, 5, 16'h0008, 0, 0, 1);
      check("dep_issue3_valid", issue_valid, 0);
      check("dep_occ2", occupancy, 2);
      idle(0);
      check("dep_blocked", issue_valid, 0);
      applyStimulus(0, 0, '0, 1, 3, 0);
      check("dep_valid", issue_valid, 1);
      check("dep_index", issue_index, 5);
      check("dep_occ", occupancy, 1);
      idle(1);
      applyStimulus(0, 0, '0, 1, 5, 0);
      check("dep_drain_occ", occupancy, 0);

      $display("[TB] back-to-back issue");
      applyStimulus(1, 0, 16'h0000, 0, 0, 0);
      applyStimulus(1, 1, 16'h0000, 0, 0, 0);
      applyStimulus(1, 2, 16'h0000, 0, 0, 0);
      check("b2b_first", issue_index, 0);
      idle(1);
      check("b2b_second", issue_index, 1);
      idle(1);
      check("b2b_third", issue_index, 2);
      idle(1);
      check("b2b_empty", issue_valid, 0);
      check("b2b_hold_idx", issue_index, 2);
      for (int k = 0; k < 3; k++) applyStimulus(0, 0, '0, 1, k, 0);
      check("b2b_occ", occupancy, 0);

      $display("[TB] round-robin wrap");
      applyStimulus(1, 13, 16'h0000, 0, 0, 0);
      idle(0);
      check("wrap_pre13", issue_index, 13);
      idle(1);
      applyStimulus(1, 2, 16'h2000, 0, 0, 0);
      applyStimulus(1, 15, 16'h2000, 0, 0, 0);
      check("wrap_blocked", issue_valid, 0);
      applyStimulus(0, 0, '0, 1, 13, 0);
      check("wrap_first_valid", issue_valid, 1);
      check("wrap_first", issue_index, 15);
      idle(1);
      check("wrap_second", issue_index, 2);
      idle(1);
      check("wrap_empty", issue_valid, 0);
      check("wrap_occ", occupancy, 2);

      $display("[TB] protocol errors");
      applyStimulus(1, 7, 16'h0004, 0, 0, 0);
      check("err_clean", err, 0);
      applyStimulus(1, 7, 16'h0000, 0, 0, 0);
      check("err_alloc", err, 1);
      check("err_row_kept", issue_valid, 0);
      idle(0);
      check("err_row_kept2", issue_valid, 0);
      applyStimulus(0, 0, '0, 1, 9, 0);
      check("err_sticky", err, 1);
      applyStimulus(0, 0, '0, 1, 2, 0);
      check("err_rel_valid", issue_valid, 1);
      check("err_rel_index", issue_index, 7);
      check("err_rel_occ", occupancy, 2);

      $display("[TB] reset abandons held offer");
      idle(0);
      check("held_valid", issue_valid, 1);
      check("held_index", issue_index, 7);
      #2 rst = 1'b0;
      #1;
      check("midrst_valid", issue_valid, 0);
      check("midrst_occ", occupancy, 0);
      check("midrst_err", err, 0);
      modelReset();
      alloc_valid = 0; complete_valid = 0; issue_ready = 0;
      @(negedge clk);
      rst = 1'b1;

      $display("[TB] random traffic");
      for (int n = 0; n < 600; n++) begin
         if (n % 200 == 199) doReset();
         busy = '0;
         issuedQ.delete();
         for (int e = 0; e < BS; e++) begin
            if (mSt[e] != S_FREE) busy[e] = 1'b1;
            if (mSt[e] == S_ISS) issuedQ.push_back(e);
         end
         ir = ($urandom_range(0, 3) != 0);
         av = ($urandom_range(0, 1) == 1);
         ai = $urandom_range(0, BS - 1);
         if ($urandom_range(0, 19) != 0) begin
            start = ai;
            for (int j = 0; j < BS; j++)
               if (mSt[(start + j) % BS] == S_FREE && mSt[ai] != S_FREE) ai = (start + j) % BS;
         end
         row = BS'($urandom & $urandom) & busy;
         cv = 0;
         ci = $urandom_range(0, BS - 1);
         if ($urandom_range(0, 19) == 0) cv = 1;
         else if (issuedQ.size() > 0 && $urandom_range(0, 9) < 4) begin
            cv = 1;
            ci = issuedQ[$urandom_range(0, issuedQ.size() - 1)];
         end
         applyStimulus(av, ai, row, cv, ci, ir);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
